cgra_tile_pe: RTL and testbench

CGRA_TILE_PE -- requirements
Module: cgra_tile_pe

---
 rtl/cgra_tile_pe_if.sv | 28 ++
 rtl/cgra_tile_pe.sv | 194 +++++++++++++++++++
 tb/tb_cgra_tile_pe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cgra_tile_pe_if.sv
// Bundle of instruction, neighbour send/receive and status signals for one CGRA tile.
// The master side offers instructions and models the neighbours; the tile is the slave.
interface cgra_tile_pe_if #(
   parameter int unsigned DW  = 32,
   parameter int unsigned NCH = 4
);
   logic                instr_valid;
   logic                instr_ready;
   logic [63:0]         instr;
   logic [NCH-1:0]      send_valid;
   logic [NCH-1:0]      send_ready;
   logic [DW-1:0]       send_data;
   logic [NCH-1:0]      recv_valid;
   logic [NCH-1:0]      recv_ready;
   logic [NCH*DW-1:0]   recv_data;
   logic                busy;
   logic                err;

   modport master (
      output instr_valid, instr, send_ready, recv_valid, recv_data,
      input  instr_ready, send_valid, send_data, recv_ready, busy, err
   );

   modport slave (
      input  instr_valid, instr, send_ready, recv_valid, recv_data,
      output instr_ready, send_valid, send_data, recv_ready, busy, err
   );
endinterface

// File: rtl/cgra_tile_pe.sv
// CGRA tile processing element: register file, ALU, local data memory and a
// blocking send/receive port towards up to four neighbours.
module cgra_tile_pe #(
   parameter int unsigned DW        = 32,
   parameter int unsigned NREG      = 32,
   parameter int unsigned MEM_DEPTH = 64,
   parameter int unsigned NCH       = 4
) (
   input logic           clk,
   input logic           rst,
   cgra_tile_pe_if.slave bus
);

   localparam int unsigned RW = $clog2(NREG);
   localparam int unsigned AW = $clog2(MEM_DEPTH);
   localparam int unsigned SW = $clog2(DW);

   localparam logic [6:0] OpNop  = 7'h00;
   localparam logic [6:0] OpAlu  = 7'h01;
   localparam logic [6:0] OpLi   = 7'h02;
   localparam logic [6:0] OpLd   = 7'h03;
   localparam logic [6:0] OpSt   = 7'h04;
   localparam logic [6:0] OpSend = 7'h05;
   localparam logic [6:0] OpRecv = 7'h06;

   typedef enum logic [1:0] {StIdle, StSend, StRecv} state_e;

   state_e          state_q;
   logic [DW-1:0]   regs_q [NREG];
   logic [DW-1:0]   mem_q [MEM_DEPTH];
   logic [NCH-1:0]  send_valid_q;
   logic [NCH-1:0]  recv_ready_q;
   logic [DW-1:0]   send_data_q;
   logic            busy_q;
   logic            err_q;
   logic [RW-1:0]   rd_q;

   logic [6:0]      opcode;
   logic [2:0]      funct;
   logic [RW-1:0]   rd_idx;
   logic [RW-1:0]   rs1_idx;
   logic [RW-1:0]   rs2_idx;
   logic [DW-1:0]   imm_ext;
   logic [DW-1:0]   rs1_val;
   logic [DW-1:0]   rs2_val;
   logic [DW-1:0]   alu_res;
   logic [DW-1:0]   addr_sum;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   recv_sel;
   logic [NCH-1:0]  ch_onehot;
   logic            ch_ok;
   logic            accept;
   logic            xfer_send;
   logic            xfer_recv;
   logic            unused_bits;

   assign opcode  = bus.instr[6:0];
   assign funct   = bus.instr[14:12];
   assign rd_idx  = bus.instr[7 +: RW];
   assign rs1_idx = bus.instr[15 +: RW];
   assign rs2_idx = bus.instr[20 +: RW];

   // Register 0 is never written and resets to zero, so a plain read yields 0.
   assign rs1_val = regs_q[rs1_idx];
   assign rs2_val = regs_q[rs2_idx];

   assign addr_sum = rs1_val + imm_ext;
   assign mem_addr = addr_sum[AW-1:0];

   assign accept    = bus.instr_valid && (state_q == StIdle);
   assign ch_ok     = 32'(funct[1:0]) < NCH;
   assign xfer_send = |(send_valid_q & bus.send_ready);
   assign xfer_recv = |(recv_ready_q & bus.recv_valid);

   assign unused_bits = ^{bus.instr[31:25], bus.instr[24:20], bus.instr[19:15],
                          bus.instr[11:7], addr_sum};

   if (DW > 32) begin : g_imm_sext
      assign imm_ext = {{(DW-32){bus.instr[63]}}, bus.instr[63:32]};
   end else begin : g_imm_trunc
      assign imm_ext = bus.instr[32 +: DW];
   end

   // Decode the one-hot channel select from funct[1:0].
   always_comb begin
      ch_onehot = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         ch_onehot[k] = (funct[1:0] == 2'(k));
      end
   end

   // Pick the inbound word of the channel currently being waited on.
   always_comb begin
      recv_sel = '0;
      for (int k = 0; k < int'(NCH); k++) begin
         if (recv_ready_q[k]) recv_sel = bus.recv_data[k*DW +: DW];
      end
   end

   // ALU result for the current instruction's funct.
   always_comb begin
      alu_res = '0;
      unique case (funct)
         3'd0: alu_res = rs1_val + rs2_val;
         3'd1: alu_res = rs1_val - rs2_val;
         3'd2: alu_res = rs1_val & rs2_val;
         3'd3: alu_res = rs1_val | rs2_val;
         3'd4: alu_res = rs1_val ^ rs2_val;
         3'd5: alu_res = rs1_val << rs2_val[SW-1:0];
         3'd6: alu_res = rs1_val >> rs2_val[SW-1:0];
         3'd7: alu_res = ($signed(rs1_val) < $signed(rs2_val)) ?
                         {{(DW-1){1'b0}}, 1'b1} : '0;
         default: alu_res = '0;
      endcase
   end

   // Control FSM, register file and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         send_valid_q <= '0;
         recv_ready_q <= '0;
         send_data_q  <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         rd_q         <= '0;
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  case (opcode)
                     OpNop: ;
                     OpAlu: if (rd_idx != '0) regs_q[rd_idx] <= alu_res;
                     OpLi:  if (rd_idx != '0) regs_q[rd_idx] <= imm_ext;
                     OpLd:  if (rd_idx != '0) regs_q[rd_idx] <= mem_q[mem_addr];
                     OpSt:  ;
                     OpSend: begin
                        if (ch_ok) begin
                           send_data_q  <= rs1_val;
                           send_valid_q <= ch_onehot;
                           busy_q       <= 1'b1;
                           state_q      <= StSend;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     OpRecv: begin
                        if (ch_ok) begin
                           recv_ready_q <= ch_onehot;
                           rd_q         <= rd_idx;
                           busy_q       <= 1'b1;
                           state_q      <= StRecv;
                        end else begin
                           err_q <= 1'b1;
                        end
                     end
                     default: err_q <= 1'b1;
                  endcase
               end
            end
            StSend: begin
               if (xfer_send) begin
                  send_valid_q <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            StRecv: begin
               if (xfer_recv) begin
                  if (rd_q != '0) regs_q[rd_q] <= recv_sel;
                  recv_ready_q <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Local data memory: not reset, written only by an accepted ST.
   always_ff @(posedge clk) begin
      if (rst && accept && (opcode == OpSt)) mem_q[mem_addr] <= rs2_val;
   end

   assign bus.instr_ready = (state_q == StIdle);
   assign bus.send_valid  = send_valid_q;
   assign bus.send_data   = send_data_q;
   assign bus.recv_ready  = recv_ready_q;
   assign bus.busy        = busy_q;
   assign bus.err         = err_q;

endmodule

// File: tb/tb_cgra_tile_pe.sv
// Directed bench for cgra_tile_pe; register contents are observed by sending them out on ch0.
module tb_cgra_tile_pe;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   logic [31:0] sb [$];

   cgra_tile_pe_if #(.DW(32), .NCH(4)) b ();

   cgra_tile_pe #(.DW(32), .NREG(32), .MEM_DEPTH(64), .NCH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls outside the bounded waits.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] enc(input logic [6:0] op, input logic [2:0] f,
                                       input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [31:0] imm);
      return {imm, 7'b0, rs2, rs1, f, rd, op};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one instruction at the next falling edge; it is accepted on the following rise.
   task automatic issue(input logic [63:0] i);
      @(negedge clk);
      chk("instr_ready", b.instr_ready, 1);
      b.instr_valid = 1'b1;
      b.instr       = i;
   endtask

   // Read register r by sending it on ch0 and comparing against the scoreboard.
   task automatic read_reg(input logic [4:0] r, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      bit seen;
      sb.push_back(exp);
      issue(enc(7'h05, 3'd0, 5'd0, r, 5'd0, 32'd0));
      @(negedge clk);
      b.instr_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         if (b.send_valid != 4'b0) seen = 1'b1;
         else @(negedge clk);
      end
      chk({tag, "_seen"}, seen, 1);
      e = sb.pop_front();
      if (seen) begin
         chk(tag, b.send_data, e);
         chk({tag, "_vld"}, b.send_valid, 4'b0001);
         b.send_ready = 4'b0001;
         @(negedge clk);
         b.send_ready = 4'b0000;
         chk({tag, "_done"}, b.send_valid, 4'b0000);
      end
   endtask

   logic [31:0] alu_exp [8];

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst           = 1'b0;
      b.instr_valid = 1'b0;
      b.instr       = '0;
      b.send_ready  = '0;
      b.recv_valid  = '0;
      b.recv_data   = '0;
      alu_exp = '{32'h800000F4, 32'h800000EC, 32'h0, 32'h800000F4,
                  32'h800000F4, 32'h00000F00, 32'h0000000F, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ready", b.instr_ready, 1);
      chk("rst_svalid", b.send_valid, 0);
      chk("rst_rready", b.recv_ready, 0);
      chk("rst_busy", b.busy, 0);
      chk("rst_err", b.err, 0);
      chk("rst_sdata", b.send_data, 0);
      rst = 1'b1;

      // Back-to-back LI, LI, ADD
      issue(enc(7'h02, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5));
      issue(enc(7'h02, 3'd0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFD));
      issue(enc(7'h01, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0));
      read_reg(5'd3, 32'd2, "add_r3");
      read_reg(5'd2, 32'hFFFFFFFD, "li_neg");

      // Store with address wrap, then load back two ways
      issue(enc(7'h02, 3'd0, 5'd1, 5'd0, 5'd0, 32'h10));
      issue(enc(7'h04, 3'd0, 5'd0, 5'd1, 5'd1, 32'd60));
      issue(enc(7'h03, 3'd0, 5'd4, 5'd1, 5'd0, 32'd60));
      issue(enc(7'h03, 3'd0, 5'd7, 5'd0, 5'd0, 32'd12));
      read_reg(5'd4, 32'h10, "ld_r4");
      read_reg(5'd7, 32'h10, "ld_word12");

      // ALU functions
      issue(enc(7'h02, 3'd0, 5'd8, 5'd0, 5'd0, 32'hF0));
      issue(enc(7'h02, 3'd0, 5'd9, 5'd0, 5'd0, 32'h80000004));
      for (int f = 0; f < 8; f++) begin
         issue(enc(7'h01, 3'(f), 5'd10, 5'd8, 5'd9, 32'd0));
         read_reg(5'd10, alu_exp[f], $sformatf("alu_f%0d", f));
      end
      issue(enc(7'h01, 3'd7, 5'd10, 5'd9, 5'd8, 32'd0));
      read_reg(5'd10, 32'd1, "slt_neg");

      // SEND ch2 with three cycles of backpressure
      issue(enc(7'h02, 3'd0, 5'd1, 5'd0, 5'd0, 32'hAB));
      sb.push_back(32'hAB);
      issue(enc(7'h05, 3'd2, 5'd0, 5'd1, 5'd0, 32'd0));
      @(negedge clk);
      b.instr_valid = 1'b0;
      b.send_ready  = 4'b1011;
      begin
         logic [31:0] e;
         e = sb.pop_front();
         for (int c = 0; c < 4; c++) begin
            chk($sformatf("send_vld_c%0d", c), b.send_valid, 4'b0100);
            chk($sformatf("send_data_c%0d", c), b.send_data, e);
            chk($sformatf("send_busy_c%0d", c), b.busy, 1);
            chk($sformatf("send_nrdy_c%0d", c), b.instr_ready, 0);
            if (c == 3) b.send_ready = 4'b0100;
            @(negedge clk);
         end
      end
      b.send_ready = 4'b0000;
      chk("send_end_vld", b.send_valid, 0);
      chk("send_end_busy", b.busy, 0);
      chk("send_end_rdy", b.instr_ready, 1);

      // RECV ch3 into r5; ch0 traffic must be ignored
      issue(enc(7'h06, 3'd3, 5'd5, 5'd0, 5'd0, 32'd0));
      @(negedge clk);
      b.instr_valid = 1'b0;
      chk("recv_rdy", b.recv_ready, 4'b1000);
      chk("recv_busy", b.busy, 1);
      b.recv_valid        = 4'b0001;
      b.recv_data[0 +: 32] = 32'hDEAD;
      @(negedge clk);
      chk("recv_ign_ch0", b.recv_ready, 4'b1000);
      b.recv_valid         = 4'b1000;
      b.recv_data[0 +: 32]  = 32'h0;
      b.recv_data[96 +: 32] = 32'h1234;
      @(negedge clk);
      b.recv_valid = 4'b0000;
      chk("recv_done", b.recv_ready, 0);
      chk("recv_idle", b.instr_ready, 1);
      read_reg(5'd5, 32'h1234, "recv_r5");

      // Illegal opcode: err set and sticky, registers untouched
      issue(enc(7'h7F, 3'd0, 5'd1, 5'd2, 5'd3, 32'h55));
      issue(enc(7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0));
      @(negedge clk);
      b.instr_valid = 1'b0;
      chk("ill_err", b.err, 1);
      read_reg(5'd1, 32'hAB, "ill_r1");

      // Reset during RECV ch1 aborts the transfer
      issue(enc(7'h06, 3'd1, 5'd5, 5'd0, 5'd0, 32'd0));
      @(negedge clk);
      b.instr_valid = 1'b0;
      chk("rrst_rdy", b.recv_ready, 4'b0010);
      rst                   = 1'b0;
      b.recv_valid          = 4'b0010;
      b.recv_data[32 +: 32] = 32'h77;
      @(negedge clk);
      rst          = 1'b1;
      b.recv_valid = 4'b0000;
      chk("rrst_err", b.err, 0);
      chk("rrst_busy", b.busy, 0);
      chk("rrst_rready", b.recv_ready, 0);
      chk("rrst_sdata", b.send_data, 0);
      read_reg(5'd5, 32'd0, "rrst_r5");
      read_reg(5'd1, 32'd0, "rrst_r1");

      // Register 0 stays zero
      issue(enc(7'h02, 3'd0, 5'd6, 5'd0, 5'd0, 32'd9));
      issue(enc(7'h02, 3'd0, 5'd0, 5'd0, 5'd0, 32'd7));
      issue(enc(7'h01, 3'd0, 5'd6, 5'd0, 5'd0, 32'd0));
      read_reg(5'd6, 32'd0, "r0_add");
      read_reg(5'd0, 32'd0, "r0_read");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
